// File: rtl/adc_pkg.sv
// Shared definitions for the ADC request scheduler: one-hot state codes,
// default timing limits and the ADC data width.
package adc_pkg;

  localparam int ADC_DW          = 8;
  localparam int FRESH_MAX_DEF   = 50000;
  localparam int TIMEOUT_MAX_DEF = 4095;

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_ARB      = 6'b000010,
    ST_START    = 6'b000100,
    ST_WAIT_SAM = 6'b001000,
    ST_WAIT_CON = 6'b010000,
    ST_DELIVER  = 6'b100000
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/adc_rr_arb.sv
// Combinational round-robin selector: first set request at or above the
// pointer, wrapping around, returned as one-hot select plus index.
module adc_rr_arb #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_sel,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [PW-1:0]     w_off;
  logic [PW:0]       w_sum;

  // Rotate so bit 0 is the requester the pointer names.
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_ptr +: NREQ];

  always_comb begin
    w_off   = '0;
    o_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = PW'(k);
        o_valid = 1'b1;
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : w_sum[PW-1:0];
  assign o_sel = o_valid ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/adc_req_sched.sv
// Round-robin scheduler sharing one serial ADC front end between requesters,
// with priming conversions for stale results and a per-conversion watchdog.
module adc_req_sched
  import adc_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int FRESH_MAX   = FRESH_MAX_DEF,
  parameter int TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic              rd_valid,
  output logic [ADC_DW-1:0] rd_data,
  output logic              rd_err,
  output logic              busy,
  output logic              adc_en,
  input  logic [ADC_DW-1:0] adc_dout,
  input  logic              adc_sam_end,
  input  logic              adc_con_ok
);

  localparam int          PW        = (NREQ > 2) ? 2 : 1;
  localparam logic [15:0] FRESH_LIM = 16'(FRESH_MAX);
  localparam logic [11:0] TMO_LIM   = 12'(TIMEOUT_MAX);

  state_t            r_state, w_state_next;
  logic              r_sam_q, r_con_q;
  logic [PW-1:0]     r_rr, r_idx;
  logic [NREQ-1:0]   r_sel;
  logic              r_dummy, r_err, r_fresh_vld;
  logic [ADC_DW-1:0] r_hold;
  logic [15:0]       r_fresh_cnt;
  logic [11:0]       r_tmo_cnt;

  logic [NREQ-1:0]   w_arb_sel;
  logic [PW-1:0]     w_arb_idx;
  logic              w_arb_valid;
  logic              w_sam_fall, w_con_fall, w_tmo;
  logic [PW:0]       w_rr_inc;
  logic [PW-1:0]     w_rr_next;

  adc_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req  (req),
    .i_ptr  (r_rr),
    .o_sel  (w_arb_sel),
    .o_idx  (w_arb_idx),
    .o_valid(w_arb_valid)
  );

  assign w_sam_fall = r_sam_q & ~adc_sam_end;
  assign w_con_fall = r_con_q & ~adc_con_ok;
  assign w_tmo      = (r_tmo_cnt == TMO_LIM);
  assign w_rr_inc   = {1'b0, r_idx} + (PW+1)'(1);
  assign w_rr_next  = (w_rr_inc == (PW+1)'(NREQ)) ? '0 : w_rr_inc[PW-1:0];

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    gnt          = '0;
    rd_valid     = 1'b0;
    rd_data      = '0;
    rd_err       = 1'b0;
    busy         = 1'b1;
    adc_en       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (|req) w_state_next = ST_ARB;
      end
      ST_ARB:   w_state_next = w_arb_valid ? ST_START : ST_IDLE;
      ST_START: begin
        adc_en       = 1'b1;
        w_state_next = ST_WAIT_SAM;
      end
      ST_WAIT_SAM: begin
        if (w_tmo)           w_state_next = ST_DELIVER;
        else if (w_sam_fall) w_state_next = ST_WAIT_CON;
      end
      ST_WAIT_CON: begin
        // A priming conversion loops straight back: the front end is idle now.
        if (w_tmo)           w_state_next = ST_DELIVER;
        else if (w_con_fall) w_state_next = r_dummy ? ST_START : ST_DELIVER;
      end
      ST_DELIVER: begin
        gnt          = r_sel;
        rd_valid     = 1'b1;
        rd_data      = r_hold;
        rd_err       = r_err;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_sam_q     <= 1'b0;
      r_con_q     <= 1'b0;
      r_rr        <= '0;
      r_idx       <= '0;
      r_sel       <= '0;
      r_dummy     <= 1'b0;
      r_err       <= 1'b0;
      r_fresh_vld <= 1'b0;
      r_hold      <= '0;
      r_fresh_cnt <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      r_sam_q     <= adc_sam_end;
      r_con_q     <= adc_con_ok;
      r_fresh_cnt <= sat_inc16(r_fresh_cnt);
      case (r_state)
        ST_ARB: begin
          if (w_arb_valid) begin
            r_idx   <= w_arb_idx;
            r_sel   <= w_arb_sel;
            r_dummy <= !r_fresh_vld || (r_fresh_cnt > FRESH_LIM);
          end
        end
        ST_START: r_tmo_cnt <= '0;
        ST_WAIT_SAM, ST_WAIT_CON: begin
          r_tmo_cnt <= r_tmo_cnt + 12'd1;
          if (w_tmo) begin
            r_err       <= 1'b1;
            r_hold      <= '0;
            r_fresh_vld <= 1'b0;
            r_dummy     <= 1'b0;
          end else if (r_state == ST_WAIT_SAM && w_sam_fall) begin
            r_hold <= adc_dout;
          end else if (r_state == ST_WAIT_CON && w_con_fall) begin
            r_fresh_cnt <= '0;
            r_fresh_vld <= 1'b1;
            r_dummy     <= 1'b0;
          end
        end
        ST_DELIVER: begin
          r_rr  <= w_rr_next;
          r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_req_sched.sv
// Directed bench for adc_req_sched with a cycle-accurate model of the serial
// ADC front end whose held byte is the previous conversion's result.
module tb_adc_req_sched;

  localparam int NREQ        = 2;
  localparam int FRESH_MAX   = 200;
  localparam int TIMEOUT_MAX = 300;

  logic       s_clk;
  logic       s_rst_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       busy;
  logic       adc_en;
  logic [7:0] adc_dout;
  logic       adc_sam_end;
  logic       adc_con_ok;

  int n_assert = 0;
  int n_fail   = 0;

  logic m_busy;
  int   m_cnt;
  int   m_idx  = 0;
  int   m_viol = 0;
  bit   m_hang = 0;

  adc_req_sched #(.NREQ(NREQ), .FRESH_MAX(FRESH_MAX), .TIMEOUT_MAX(TIMEOUT_MAX)) dut (
    .s_clk      (s_clk),
    .s_rst_n    (s_rst_n),
    .req        (req),
    .gnt        (gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .busy       (busy),
    .adc_en     (adc_en),
    .adc_dout   (adc_dout),
    .adc_sam_end(adc_sam_end),
    .adc_con_ok (adc_con_ok)
  );

  initial begin
    s_clk = 1'b0;
    forever #5 s_clk = ~s_clk;
  end

  // Result produced by conversion number n.
  function automatic logic [7:0] tab(input int n);
    case (n)
      0: return 8'hA5;   1: return 8'h3C;   2: return 8'h5A;   3: return 8'hC3;
      4: return 8'h11;   5: return 8'h22;   6: return 8'h33;   7: return 8'h44;
      8: return 8'h77;   9: return 8'h96;  10: return 8'hE1;  11: return 8'h4B;
      default: return 8'hFF;
    endcase
  endfunction

  // Front-end model: con_ok up at STA, sam_end pulse, con_ok down at end.
  always @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      m_busy      <= 1'b0;
      m_cnt       <= 0;
      adc_sam_end <= 1'b0;
      adc_con_ok  <= 1'b0;
      adc_dout    <= 8'h00;
    end else begin
      if (adc_en && m_busy) m_viol <= m_viol + 1;
      if (adc_en && !m_busy && !m_hang) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        case (m_cnt)
          0:  adc_con_ok  <= 1'b1;
          4:  adc_sam_end <= 1'b1;
          8:  adc_sam_end <= 1'b0;
          15: begin
            adc_con_ok <= 1'b0;
            m_busy     <= 1'b0;
            adc_dout   <= tab(m_idx);
            m_idx      <= m_idx + 1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [1:0] rv, input int budget,
                         output logic [1:0] g, output logic [7:0] d, output logic e,
                         output int n_en, output int first_en, output int cyc, output bit ok);
    req = rv; g = '0; d = '0; e = 1'b0;
    n_en = 0; first_en = -1; cyc = 0; ok = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge s_clk);
      if (adc_en) begin
        n_en++;
        if (first_en < 0) first_en = k;
      end
      if (rd_valid) begin
        g = gnt; d = rd_data; e = rd_err; cyc = k; ok = 1'b1;
        break;
      end
    end
    $display("txn req=%b ok=%0d gnt=%b data=0x%02h err=%0d adc_en=%0d first_en=%0d cyc=%0d",
             rv, ok, g, d, e, n_en, first_en, cyc);
  endtask

  task automatic idle_cycles(input int n);
    req = 2'b00;
    repeat (n) @(negedge s_clk);
  endtask

  logic [1:0] g;
  logic [7:0] d;
  logic       e;
  int         n_en, first_en, cyc;
  bit         ok, seen;
  logic [1:0] exp_g [4];
  logic [7:0] exp_d [4];

  initial begin
    s_rst_n = 1'b0;
    req     = 2'b00;
    repeat (3) @(negedge s_clk);
    check("rst_gnt", gnt, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_busy", busy, 0);
    check("rst_adc_en", adc_en, 0);
    s_rst_n = 1'b1;

    // Stale after reset: priming conversion then the real one.
    run_txn(2'b01, 200, g, d, e, n_en, first_en, cyc, ok);
    check("t1_done", ok, 1);
    check("t1_adc_en_cnt", n_en, 2);
    check("t1_first_en", first_en, 2);
    check("t1_cyc", cyc, 38);
    check("t1_gnt", g, 2'b01);
    check("t1_data", d, 8'hA5);
    check("t1_err", e, 0);
    idle_cycles(10);

    // Fresh: a single conversion, rd_valid one cycle after con_ok falls.
    run_txn(2'b01, 200, g, d, e, n_en, first_en, cyc, ok);
    check("t2_done", ok, 1);
    check("t2_adc_en_cnt", n_en, 1);
    check("t2_first_en", first_en, 2);
    check("t2_cyc", cyc, 20);
    check("t2_gnt", g, 2'b01);
    check("t2_data", d, 8'h3C);
    idle_cycles(FRESH_MAX + 100);

    // Held result aged past the limit.
    run_txn(2'b10, 200, g, d, e, n_en, first_en, cyc, ok);
    check("t3_done", ok, 1);
    check("t3_adc_en_cnt", n_en, 2);
    check("t3_gnt", g, 2'b10);
    check("t3_data", d, 8'hC3);

    // Both requesting continuously: strict alternation.
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 200, g, d, e, n_en, first_en, cyc, ok);
      check($sformatf("t4_%0d_done", i), ok, 1);
      check($sformatf("t4_%0d_gnt", i), g, exp_g[i]);
      check($sformatf("t4_%0d_data", i), d, exp_d[i]);
      check($sformatf("t4_%0d_adc_en_cnt", i), n_en, 1);
    end
    check("t4_en_while_busy", m_viol, 0);
    idle_cycles(5);

    // Front end hangs: watchdog delivers an error with zero data.
    m_hang = 1'b1;
    run_txn(2'b01, TIMEOUT_MAX + 100, g, d, e, n_en, first_en, cyc, ok);
    check("t5_done", ok, 1);
    check("t5_adc_en_cnt", n_en, 1);
    check("t5_tmo_latency", cyc - first_en, TIMEOUT_MAX + 2);
    check("t5_gnt", g, 2'b01);
    check("t5_err", e, 1);
    check("t5_data", d, 8'h00);
    idle_cycles(5);
    m_hang = 1'b0;

    run_txn(2'b01, 200, g, d, e, n_en, first_en, cyc, ok);
    check("t5b_done", ok, 1);
    check("t5b_adc_en_cnt", n_en, 2);
    check("t5b_data", d, 8'h96);
    check("t5b_err", e, 0);
    idle_cycles(5);

    // Asynchronous reset while waiting for sam_end.
    req  = 2'b10;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge s_clk);
      if (adc_en) seen = 1'b1;
    end
    check("t6_en_seen", seen, 1);
    repeat (2) @(negedge s_clk);
    check("t6_busy_pre", busy, 1);
    #2 s_rst_n = 1'b0;
    #1;
    check("t6_rst_gnt", gnt, 0);
    check("t6_rst_rd_valid", rd_valid, 0);
    check("t6_rst_rd_data", rd_data, 0);
    check("t6_rst_rd_err", rd_err, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_adc_en", adc_en, 0);
    req = 2'b00;
    @(negedge s_clk);
    s_rst_n = 1'b1;

    run_txn(2'b10, 200, g, d, e, n_en, first_en, cyc, ok);
    check("t6_done", ok, 1);
    check("t6_adc_en_cnt", n_en, 2);
    check("t6_gnt", g, 2'b10);
    check("t6_data", d, 8'h4B);
    check("t6_err", e, 0);
    idle_cycles(3);
    check("end_en_while_busy", m_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
